dpram_port_arb: RTL and testbench

//  Two-requester arbiter that shares one port of the byte-addressable 32-bit dual-port RAM.

---
 rtl/dpram_port_arb.sv | 134 +++++++++++++
 tb/tb_dpram_port_arb.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_port_arb.sv
// Two-requester arbiter in front of one port of the 32-bit dual-port RAM.
// Read responses are steered back to their issuer through 2-entry FWFT FIFOs.
module dpram_port_arb #(
  parameter int AW   = 15,
  parameter bit PRIO = 1'b0
) (
  input  logic          clk,
  input  logic          rstf,
  input  logic          t_r0_valid,
  output logic          t_r0_ready,
  input  logic          t_r0_we,
  input  logic [AW-1:0] t_r0_addr,
  input  logic [31:0]   t_r0_data,
  input  logic [3:0]    t_r0_mask,
  input  logic          t_r1_valid,
  output logic          t_r1_ready,
  input  logic          t_r1_we,
  input  logic [AW-1:0] t_r1_addr,
  input  logic [31:0]   t_r1_data,
  input  logic [3:0]    t_r1_mask,
  output logic          i_r0_valid,
  input  logic          i_r0_ready,
  output logic [31:0]   i_r0_data,
  output logic          i_r1_valid,
  input  logic          i_r1_ready,
  output logic [31:0]   i_r1_data,
  output logic          i_m_valid,
  input  logic          i_m_ready,
  output logic          i_m_we,
  output logic [AW-1:0] i_m_addr,
  output logic [31:0]   i_m_data,
  output logic [3:0]    i_m_mask,
  input  logic          t_m_valid,
  output logic          t_m_ready,
  input  logic [31:0]   t_m_data,
  output logic          err_orphan
);

  logic [1:0][1:0][31:0] mem_q, mem_d;
  logic [1:0][1:0]       cnt_q, cnt_d;
  logic [1:0]            wp_q, wp_d;
  logic [1:0]            rp_q, rp_d;
  logic                  pend_valid_q, pend_valid_d;
  logic                  pend_id_q, pend_id_d;
  logic                  last_gnt_q, last_gnt_d;
  logic                  err_orphan_q, err_orphan_d;
  logic                  rst_q, rst_d;

  logic [1:0] cred0, cred1;
  logic       elig0, elig1;
  logic       gnt0, gnt1;
  logic       fire;
  logic [1:0] push, pop, rdy;

  always_comb begin
    cred0 = cnt_q[0] + {1'b0, pend_valid_q & ~pend_id_q};
    cred1 = cnt_q[1] + {1'b0, pend_valid_q & pend_id_q};
    elig0 = t_r0_valid & (t_r0_we | (cred0 < 2'd2));
    elig1 = t_r1_valid & (t_r1_we | (cred1 < 2'd2));
    // r1 takes a conflict only in round-robin mode when r0 went last
    gnt1  = elig1 & (~elig0 | ((PRIO == 1'b0) & ~last_gnt_q));
    gnt0  = elig0 & ~gnt1;
  end

  assign i_m_valid  = elig0 | elig1;
  assign i_m_we     = gnt1 ? t_r1_we   : t_r0_we;
  assign i_m_addr   = gnt1 ? t_r1_addr : t_r0_addr;
  assign i_m_data   = gnt1 ? t_r1_data : t_r0_data;
  assign i_m_mask   = gnt1 ? t_r1_mask : t_r0_mask;
  assign t_r0_ready = gnt0 & i_m_ready;
  assign t_r1_ready = gnt1 & i_m_ready;
  assign t_m_ready  = 1'b1;
  assign fire       = i_m_valid & i_m_ready;

  assign i_r0_valid = rstf & (cnt_q[0] != 2'd0);
  assign i_r1_valid = rstf & (cnt_q[1] != 2'd0);
  assign i_r0_data  = mem_q[0][rp_q[0]];
  assign i_r1_data  = mem_q[1][rp_q[1]];
  assign err_orphan = err_orphan_q;

  assign rdy = {i_r1_ready, i_r0_ready};

  always_comb begin
    mem_d        = mem_q;
    cnt_d        = cnt_q;
    wp_d         = wp_q;
    rp_d         = rp_q;
    push         = 2'b00;
    pop          = 2'b00;
    pend_valid_d = fire & ~i_m_we;
    pend_id_d    = pend_id_q;
    last_gnt_d   = last_gnt_q;
    rst_d        = 1'b0;
    err_orphan_d = err_orphan_q
                 | (t_m_valid & ~pend_valid_q & ~rst_q);
    if (fire) last_gnt_d = gnt1;
    if (fire & ~i_m_we) pend_id_d = gnt1;
    for (int n = 0; n < 2; n++) begin
      push[n] = t_m_valid & pend_valid_q
              & (pend_id_q == n[0]);
      pop[n]  = (cnt_q[n] != 2'd0) & rdy[n];
      if (push[n]) mem_d[n][wp_q[n]] = t_m_data;
      wp_d[n]  = wp_q[n] ^ push[n];
      rp_d[n]  = rp_q[n] ^ pop[n];
      cnt_d[n] = cnt_q[n] + {1'b0, push[n]}
               - {1'b0, pop[n]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rstf) begin
      mem_q        <= '0;
      cnt_q        <= '0;
      wp_q         <= '0;
      rp_q         <= '0;
      pend_valid_q <= 1'b0;
      pend_id_q    <= 1'b0;
      last_gnt_q   <= 1'b1;
      err_orphan_q <= 1'b0;
      rst_q        <= 1'b1;
    end else begin
      mem_q        <= mem_d;
      cnt_q        <= cnt_d;
      wp_q         <= wp_d;
      rp_q         <= rp_d;
      pend_valid_q <= pend_valid_d;
      pend_id_q    <= pend_id_d;
      last_gnt_q   <= last_gnt_d;
      err_orphan_q <= err_orphan_d;
      rst_q        <= rst_d;
    end
  end

endmodule

// File: tb/tb_dpram_port_arb.sv
// Bench for dpram_port_arb: small RAM model, acceptance logger feeding
// per-requester expected queues, and a monitor checking every response.
module tb_dpram_port_arb;

  localparam int AW = 15;

  logic          clk = 1'b0;
  logic          rstf;
  logic          t_r0_valid, t_r0_ready, t_r0_we;
  logic [AW-1:0] t_r0_addr;
  logic [31:0]   t_r0_data;
  logic [3:0]    t_r0_mask;
  logic          t_r1_valid, t_r1_ready, t_r1_we;
  logic [AW-1:0] t_r1_addr;
  logic [31:0]   t_r1_data;
  logic [3:0]    t_r1_mask;
  logic          i_r0_valid, i_r0_ready;
  logic [31:0]   i_r0_data;
  logic          i_r1_valid, i_r1_ready;
  logic [31:0]   i_r1_data;
  logic          i_m_valid, i_m_ready, i_m_we;
  logic [AW-1:0] i_m_addr;
  logic [31:0]   i_m_data;
  logic [3:0]    i_m_mask;
  logic          t_m_valid, t_m_ready;
  logic [31:0]   t_m_data;
  logic          err_orphan;

  logic        ld, inj, rsp_v;
  logic [31:0] rsp_d;
  logic [31:0] ram     [64];
  logic [31:0] exp_mem [64];
  logic [31:0] exp0[$], exp1[$];
  logic        gnt_log[$];
  int          n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  dpram_port_arb #(.AW(AW), .PRIO(1'b0)) dut (
    .clk(clk), .rstf(rstf),
    .t_r0_valid(t_r0_valid), .t_r0_ready(t_r0_ready),
    .t_r0_we(t_r0_we), .t_r0_addr(t_r0_addr),
    .t_r0_data(t_r0_data), .t_r0_mask(t_r0_mask),
    .t_r1_valid(t_r1_valid), .t_r1_ready(t_r1_ready),
    .t_r1_we(t_r1_we), .t_r1_addr(t_r1_addr),
    .t_r1_data(t_r1_data), .t_r1_mask(t_r1_mask),
    .i_r0_valid(i_r0_valid), .i_r0_ready(i_r0_ready),
    .i_r0_data(i_r0_data),
    .i_r1_valid(i_r1_valid), .i_r1_ready(i_r1_ready),
    .i_r1_data(i_r1_data),
    .i_m_valid(i_m_valid), .i_m_ready(i_m_ready),
    .i_m_we(i_m_we), .i_m_addr(i_m_addr),
    .i_m_data(i_m_data), .i_m_mask(i_m_mask),
    .t_m_valid(t_m_valid), .t_m_ready(t_m_ready),
    .t_m_data(t_m_data), .err_orphan(err_orphan)
  );

  // RAM model: 64 words, one-cycle read latency
  always @(posedge clk) begin
    rsp_v <= i_m_valid & i_m_ready & ~i_m_we;
    rsp_d <= ram[i_m_addr[7:2]];
    if (ld) begin
      for (int i = 0; i < 64; i++) ram[i] <= 32'h1000_0000 + i;
    end else if (i_m_valid & i_m_ready & i_m_we) begin
      for (int b = 0; b < 4; b++)
        if (i_m_mask[b])
          ram[i_m_addr[7:2]][b*8 +: 8] <= i_m_data[b*8 +: 8];
    end
  end
  assign t_m_valid = rsp_v | inj;
  assign t_m_data  = rsp_d;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // acceptance logger and response monitor
  always @(negedge clk) begin
    if (rstf && t_r0_valid && t_r0_ready) begin
      gnt_log.push_back(1'b0);
      if (!t_r0_we) begin
        exp0.push_back(exp_mem[t_r0_addr[7:2]]);
        chk("r0_credit", 32'(exp0.size() <= 2), 32'd1);
      end
    end
    if (rstf && t_r1_valid && t_r1_ready) begin
      gnt_log.push_back(1'b1);
      if (!t_r1_we) begin
        exp1.push_back(exp_mem[t_r1_addr[7:2]]);
        chk("r1_credit", 32'(exp1.size() <= 2), 32'd1);
      end
    end
    if (i_r0_valid && i_r0_ready) begin
      if (exp0.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL r0_unexpected: got %h expected none", i_r0_data);
      end else chk("r0_data", i_r0_data, exp0.pop_front());
    end
    if (i_r1_valid && i_r1_ready) begin
      if (exp1.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL r1_unexpected: got %h expected none", i_r1_data);
      end else chk("r1_data", i_r1_data, exp1.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic a0, a1;

  initial begin
    rstf = 1'b0; ld = 1'b1; inj = 1'b0;
    t_r0_valid = 0; t_r0_we = 0; t_r0_addr = '0;
    t_r0_data = '0; t_r0_mask = '0;
    t_r1_valid = 0; t_r1_we = 0; t_r1_addr = '0;
    t_r1_data = '0; t_r1_mask = '0;
    i_r0_ready = 1; i_r1_ready = 1; i_m_ready = 1;
    for (int i = 0; i < 64; i++) exp_mem[i] = 32'h1000_0000 + i;
    step(); step();
    chk("rst_r0_valid", 32'(i_r0_valid), 0);
    chk("rst_r1_valid", 32'(i_r1_valid), 0);
    chk("rst_err", 32'(err_orphan), 0);
    ld = 1'b0; rstf = 1'b1;
    step();

    // single r0 read, latency T -> T+2
    t_r0_valid = 1; t_r0_addr = 15'h10;
    #1;
    chk("t1_m_valid", 32'(i_m_valid), 1);
    chk("t1_m_addr", 32'(i_m_addr), 32'h10);
    chk("t1_r0_ready", 32'(t_r0_ready), 1);
    chk("t1_r1_ready", 32'(t_r1_ready), 0);
    step();
    t_r0_valid = 0;
    chk("t1_valid_T1", 32'(i_r0_valid), 0);
    step();
    chk("t1_valid_T2", 32'(i_r0_valid), 1);
    chk("t1_data_T2", i_r0_data, 32'h1000_0004);
    chk("t1_r1_none", 32'(i_r1_valid), 0);
    repeat (3) step();

    // both read every cycle: grants alternate, r1 first (r0 went last)
    gnt_log.delete();
    t_r0_addr = 15'h00; t_r1_addr = 15'h40;
    t_r0_valid = 1; t_r1_valid = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a0 = t_r0_ready; a1 = t_r1_ready;
      step();
      if (a0) t_r0_addr = t_r0_addr + 15'd4;
      if (a1) t_r1_addr = t_r1_addr + 15'd4;
    end
    t_r0_valid = 0; t_r1_valid = 0;
    repeat (4) step();
    chk("t2_grants", gnt_log.size(), 8);
    for (int i = 0; i < 8 && i < gnt_log.size(); i++)
      chk("t2_alt", 32'(gnt_log[i]), (i % 2 == 0) ? 32'd1 : 32'd0);

    // credit stall with r1 response path blocked
    i_r1_ready = 0;
    t_r1_valid = 1; t_r1_addr = 15'h80;
    #1 chk("t3_rdA", 32'(t_r1_ready), 1);
    step();
    t_r1_addr = 15'h84;
    #1 chk("t3_rdB", 32'(t_r1_ready), 1);
    step();
    t_r1_addr = 15'h88;
    #1 chk("t3_stall0", 32'(t_r1_ready), 0);
    step();
    chk("t3_stall1", 32'(t_r1_ready), 0);
    step();
    chk("t3_stall2", 32'(t_r1_ready), 0);
    i_r1_ready = 1;
    #1 chk("t3_popcyc", 32'(t_r1_ready), 0);
    step();
    chk("t3_release", 32'(t_r1_ready), 1);
    step();
    t_r1_valid = 0;
    repeat (4) step();

    // masked write by r1, read back by r0
    t_r1_valid = 1; t_r1_we = 1; t_r1_addr = 15'h20;
    t_r1_data = 32'hAABB_CCDD; t_r1_mask = 4'b0101;
    #1 chk("t4_wr_ready", 32'(t_r1_ready), 1);
    step();
    t_r1_valid = 0; t_r1_we = 0;
    repeat (3) step();
    chk("t4_no_rsp", 32'(i_r1_valid), 0);
    chk("t4_err", 32'(err_orphan), 0);
    exp_mem[8] = 32'h10BB_00DD;
    t_r0_valid = 1; t_r0_addr = 15'h20;
    step();
    t_r0_valid = 0;
    repeat (3) step();

    // orphan response
    inj = 1;
    step();
    inj = 0;
    chk("t5_err_set", 32'(err_orphan), 1);
    repeat (3) step();
    chk("t5_err_sticky", 32'(err_orphan), 1);

    // reset one cycle after an accepted read
    t_r0_valid = 1; t_r0_addr = 15'h10;
    step();
    t_r0_valid = 0; rstf = 0;
    step();
    chk("t6_rst_valid", 32'(i_r0_valid), 0);
    chk("t6_rst_err", 32'(err_orphan), 0);
    step();
    exp0.delete(); exp1.delete();
    rstf = 1;
    step();
    chk("t6_post_v0", 32'(i_r0_valid), 0);
    step();
    chk("t6_post_v0b", 32'(i_r0_valid), 0);
    chk("t6_post_err", 32'(err_orphan), 0);
    t_r0_valid = 1; t_r0_addr = 15'h00;
    t_r1_valid = 1; t_r1_addr = 15'h40;
    #1;
    chk("t6_r0_first", 32'(t_r0_ready), 1);
    chk("t6_r1_waits", 32'(t_r1_ready), 0);
    step();
    t_r0_valid = 0;
    #1 chk("t6_r1_next", 32'(t_r1_ready), 1);
    step();
    t_r1_valid = 0;
    repeat (5) step();

    chk("end_q0_empty", exp0.size(), 0);
    chk("end_q1_empty", exp1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
